wb_queue: RTL and testbench
===========================

Name: wb_queue

Overview:
- Write-back queue that sits in front of the register file write port (we3/wa3/wd3).
- Accepts results from the execute/memory stages through a valid/ready handshake and buffers up to DEPTH of them in order.
- Drains one entry per cycle into the register file unless the write port is borrowed (port_busy).
- Provides a youngest-match lookup so the read stage can see pending, not-yet-committed values.

Parameters:
DEPTH, 4, number of buffered write entries; power of two, minimum 2
DW, 64, data width of each write
AW, 5, register address width

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  producer has a write result
in_ready  out  1  queue can accept a write this cycle
in_wa  in  AW  destination register
in_wd  in  DW  write data
port_busy  in  1  register file write port unavailable this cycle; no drain
we3  out  1  register file write enable
wa3  out  AW  register file write address
wd3  out  DW  register file write data
look_ra  in  AW  register number to search for
look_hit  out  1  a pending entry targets look_ra
look_data  out  DW  data of the youngest pending entry for look_ra
count  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Storage: circular buffer of DEPTH entries, with head pointer, tail pointer and count registers. Pointers wrap modulo DEPTH.
- Reset, applied on a clk edge with reset=1:
  - head=0, tail=0, count=0.
  - Entry contents are don't-care.
  - Outputs the next cycle: in_ready=1, we3=0, wa3=0, wd3=0, look_hit=0, look_data=0, count=0.
  - Reset overrides any push or pop in the same cycle; pending writes are discarded.
- Handshake:
  - in_ready = (count != DEPTH).
  - A push occurs at a clk edge when in_valid && in_ready.
  - No combinational path from in_valid to in_ready.
- X31 filter: a push with in_wa == 31 completes the handshake but stores nothing, and count is unchanged.
- Drain:
  - we3 = (count != 0) && !port_busy.
  - wa3/wd3 are driven from the head entry; both are 0 when count == 0.
  - The register file writes on the same edge, so at that edge head advances and count decrements.
  - Latency: a write pushed at edge N into an empty queue with port_busy=0 is presented during cycle N+1 and committed at edge N+1.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - When full, in_ready=0 even if a pop occurs this cycle; there is no push-through.
- Full: count == DEPTH. Pushes are blocked and drain continues when port_busy=0.
- Empty: count == 0, we3=0. port_busy has no effect.
- Ordering: commits leave in push order. Two writes to the same register both commit, and the later value remains.
- Lookup (combinational):
  - Scans valid entries from youngest (tail-1) to oldest (head).
  - The first entry with wa == look_ra sets look_hit=1 and look_data to that entry's data; otherwise both are 0.
  - look_ra == 31 always gives hit=0, data=0.
  - The head entry being committed this cycle still counts as a hit.

Optional Feature:
WB_BYPASS_EN
- Defined: lookup as specified above.
- Undefined: no lookup logic is built; look_hit and look_data are tied to 0; look_ra is ignored.
- Queue and drain behaviour are identical in both builds.

Decomposition:
- Package wb_pkg holds:
  - Constant XZR_ADDR = 5'd31.
  - Typedef wb_entry_t, a struct with wa[AW-1:0] and wd[DW-1:0].
  - A function returning the occupancy width from DEPTH.
- One sub-module, wb_lookup: combinational youngest-first priority matcher over the entry array, taking valid mask, head, tail and look_ra. It is instantiated only under WB_BYPASS_EN.

Test Plan:
- Reset mid-operation: push 3 entries, hold port_busy=1, assert reset for one edge -> count=0, we3=0, in_ready=1 next cycle; nothing was committed.
- Basic drain: push (wa=5, wd=0xAA) at edge N with port_busy=0 -> during cycle N+1 we3=1, wa3=5, wd3=0xAA; at N+2 we3=0, count=0.
- Fill and block: port_busy=1, push 4 entries (wa=1..4) -> count=4, in_ready=0. A 5th in_valid is not accepted. Drop port_busy -> commits wa=1,2,3,4 on consecutive cycles, in_ready=1 after the first pop.
- XZR filter: push wa=31, wd=0xFF -> handshake completes, count stays 0, we3 never asserts.
- Bypass (WB_BYPASS_EN defined): port_busy=1, push (7,0x10) then (7,0x20), look_ra=7 -> look_hit=1, look_data=0x20. After both commit -> look_hit=0. look_ra=31 -> hit=0.
- Simultaneous push/pop at count=2 with port_busy=0 -> count stays 2; head and tail wrap correctly over 3×DEPTH operations; commit order matches push order.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back queue.
// Entry widths here must match the wb_queue AW/DW parameters.
package wb_pkg;
  localparam int WB_AW = 5;
  localparam int WB_DW = 64;
  localparam logic [4:0] XZR_ADDR = 5'd31;

  typedef struct packed {
    logic [WB_AW-1:0] wa;
    logic [WB_DW-1:0] wd;
  } wb_entry_t;

  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/wb_lookup.sv
// Youngest-first match of look_ra against the pending write-back entries.
module wb_lookup
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  wb_entry_t              entries [DEPTH],
  input  logic [DEPTH-1:0]       valid,
  input  logic [PW-1:0]          head,
  input  logic [PW-1:0]          tail,
  input  logic [WB_AW-1:0]       look_ra,
  output logic                   look_hit,
  output logic [WB_DW-1:0]       look_data
);

  // Walk from tail-1 back towards head; the first valid match is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    logic          done;
    look_hit  = 1'b0;
    look_data = '0;
    done      = 1'b0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = tail - PW'(k) - PW'(1);
      if (!done && valid[idx] && (entries[idx].wa == look_ra) && (look_ra != XZR_ADDR)) begin
        look_hit  = 1'b1;
        look_data = entries[idx].wd;
        done      = 1'b1;
      end
      if (idx == head) done = 1'b1;
    end
  end

endmodule

// File: rtl/wb_queue.sv
// In-order write-back queue in front of the register file write port.
// Build macro WB_BYPASS_EN enables the pending-value lookup; otherwise look_* are tied to 0.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = WB_DW,
  parameter int AW    = WB_AW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_wa,
  input  logic [DW-1:0]          in_wd,
  input  logic                   port_busy,
  output logic                   we3,
  output logic [AW-1:0]          wa3,
  output logic [DW-1:0]          wd3,
  input  logic [AW-1:0]          look_ra,
  output logic                   look_hit,
  output logic [DW-1:0]          look_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = occ_width(DEPTH);

  wb_entry_t      r_mem [DEPTH];
  logic [PW-1:0]  r_head;
  logic [PW-1:0]  r_tail;
  logic [CW-1:0]  r_count;
  logic           w_push;
  logic           w_pop;
  logic           w_nonempty;

  // Ready depends only on occupancy, so there is no path from in_valid.
  assign in_ready   = (r_count != CW'(DEPTH));
  assign w_nonempty = (r_count != '0);
  assign w_push     = in_valid && in_ready && (in_wa != AW'(XZR_ADDR));
  assign w_pop      = w_nonempty && !port_busy;

  assign we3   = w_pop;
  assign wa3   = w_nonempty ? r_mem[r_head].wa : '0;
  assign wd3   = w_nonempty ? r_mem[r_head].wd : '0;
  assign count = r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_tail] <= {in_wa, in_wd};
  end

`ifdef WB_BYPASS_EN
  logic [DEPTH-1:0] w_valid;

  always_comb begin
    w_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid[i] = ({1'b0, PW'(i) - r_head} < r_count);
    end
  end

  wb_lookup #(.DEPTH(DEPTH), .PW(PW)) u_lookup (
    .entries   (r_mem),
    .valid     (w_valid),
    .head      (r_head),
    .tail      (r_tail),
    .look_ra   (look_ra),
    .look_hit  (look_hit),
    .look_data (look_data)
  );
`else
  logic w_unused_look;
  assign w_unused_look = ^look_ra;
  assign look_hit      = 1'b0;
  assign look_data     = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Scoreboard bench for wb_queue: queue-level reference model plus decoupled commit monitor.
module tb_wb_queue;
  import wb_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 64;
  localparam int EW    = AW + DW;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [AW-1:0]          in_wa;
  logic [DW-1:0]          in_wd;
  logic                   port_busy;
  logic                   we3;
  logic [AW-1:0]          wa3;
  logic [DW-1:0]          wd3;
  logic [AW-1:0]          look_ra;
  logic                   look_hit;
  logic [DW-1:0]          look_data;
  logic [$clog2(DEPTH):0] count;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] pend_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic          mon_en  = 1'b0;

  wb_queue #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wa     (in_wa),
    .in_wd     (in_wd),
    .port_busy (port_busy),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .look_ra   (look_ra),
    .look_hit  (look_hit),
    .look_data (look_data),
    .count     (count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: pending writes as a plain FIFO list
  always @(posedge clk) begin
    if (reset) begin
      pend_q.delete();
      exp_q.delete();
    end else begin
      logic do_push;
      logic do_pop;
      do_pop  = (pend_q.size() != 0) && !port_busy;
      do_push = in_valid && (pend_q.size() != DEPTH) && (in_wa != 5'd31);
      if (do_pop) void'(pend_q.pop_front());
      if (do_push) begin
        pend_q.push_back({in_wa, in_wd});
        exp_q.push_back({in_wa, in_wd});
      end
    end
  end

  function automatic logic [DW:0] young_match(input logic [AW-1:0] ra);
    if (ra == 5'd31) return '0;
    for (int i = pend_q.size() - 1; i >= 0; i--) begin
      if (pend_q[i][EW-1:DW] == ra) return {1'b1, pend_q[i][DW-1:0]};
    end
    return '0;
  endfunction

  // monitor: compares on the falling edge, pops the scoreboard on each commit
  always @(negedge clk) begin
    if (mon_en) begin
      logic [DW:0]   lk;
      logic [EW-1:0] e;
      int            sz;
      sz = pend_q.size();
      chk("count", DW'(count), DW'(sz));
      chk("in_ready", DW'(in_ready), DW'(sz != DEPTH));
      chk("we3", DW'(we3), DW'((sz != 0) && !port_busy));
      if (sz == 0) begin
        chk("wa3_idle", DW'(wa3), '0);
        chk("wd3_idle", wd3, '0);
      end
`ifdef WB_BYPASS_EN
      lk = young_match(look_ra);
`else
      lk = '0;
`endif
      chk("look_hit", DW'(look_hit), DW'(lk[DW]));
      chk("look_data", look_data, lk[DW-1:0]);
      if (we3) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_commit", DW'(1), DW'(0));
        end else begin
          e = exp_q.pop_front();
          chk("commit_wa", DW'(wa3), DW'(e[EW-1:DW]));
          chk("commit_wd", wd3, e[DW-1:0]);
        end
      end
    end
  end

  // driver: apply inputs, then sample 2ns after the edge they are used on
  task automatic step(input logic rst, input logic v, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic busy, input logic [AW-1:0] ra);
    reset     = rst;
    in_valid  = v;
    in_wa     = wa;
    in_wd     = wd;
    port_busy = busy;
    look_ra   = ra;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic busy, input logic [AW-1:0] ra);
    step(1'b0, 1'b0, '0, '0, busy, ra);
  endtask

  initial begin
    step(1'b1, 1'b0, '0, '0, 1'b0, '0);
    mon_en = 1'b1;
    chk("rst_count", DW'(count), '0);
    chk("rst_ready", DW'(in_ready), DW'(1));
    chk("rst_we3", DW'(we3), '0);
    chk("rst_wa3", DW'(wa3), '0);
    chk("rst_look", DW'(look_hit), '0);

    // reset mid-operation discards pending writes
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, AW'(i + 1), DW'(i + 'h30), 1'b1, '0);
    chk("mid_count3", DW'(count), DW'(3));
    step(1'b1, 1'b0, '0, '0, 1'b1, '0);
    chk("midrst_count", DW'(count), '0);
    chk("midrst_ready", DW'(in_ready), DW'(1));
    chk("midrst_we3", DW'(we3), '0);

    // basic drain latency
    step(1'b0, 1'b1, 5'd5, 64'hAA, 1'b0, '0);
    chk("drain_we3", DW'(we3), DW'(1));
    chk("drain_wa3", DW'(wa3), DW'(5));
    chk("drain_wd3", wd3, 64'hAA);
    idle(1'b0, '0);
    chk("drain_done_we3", DW'(we3), '0);
    chk("drain_done_count", DW'(count), '0);

    // fill while the port is busy, then release
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, AW'(i), DW'(i * 'h11), 1'b1, '0);
    chk("full_count", DW'(count), DW'(4));
    chk("full_ready", DW'(in_ready), '0);
    step(1'b0, 1'b1, 5'd9, 64'h99, 1'b1, '0);
    chk("full_blocked", DW'(count), DW'(4));
    chk("full_head_wa3", DW'(wa3), DW'(1));
    idle(1'b0, '0);
    chk("after_pop_ready", DW'(in_ready), DW'(1));
    for (int i = 0; i < 4; i++) idle(1'b0, '0);
    chk("fill_drained", DW'(count), '0);

    // x31 writes are swallowed
    step(1'b0, 1'b1, 5'd31, 64'hFF, 1'b0, '0);
    chk("xzr_count", DW'(count), '0);
    chk("xzr_we3", DW'(we3), '0);

    // youngest-match lookup
    step(1'b0, 1'b1, 5'd7, 64'h10, 1'b1, 5'd7);
    step(1'b0, 1'b1, 5'd7, 64'h20, 1'b1, 5'd7);
`ifdef WB_BYPASS_EN
    chk("byp_hit", DW'(look_hit), DW'(1));
    chk("byp_data", look_data, 64'h20);
`else
    chk("byp_hit_off", DW'(look_hit), '0);
    chk("byp_data_off", look_data, '0);
`endif
    idle(1'b1, 5'd31);
    chk("byp_x31_hit", DW'(look_hit), '0);
    idle(1'b0, 5'd7);
    idle(1'b0, 5'd7);
    chk("byp_gone_hit", DW'(look_hit), '0);

    // steady push+pop at occupancy 2, wrapping the pointers
    step(1'b0, 1'b1, 5'd1, 64'h100, 1'b1, '0);
    step(1'b0, 1'b1, 5'd2, 64'h101, 1'b1, '0);
    for (int i = 0; i < 3 * DEPTH; i++) begin
      step(1'b0, 1'b1, AW'(i % 8), DW'('h200 + i), 1'b0, '0);
      chk("stream_count", DW'(count), DW'(2));
    end

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int r;
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      r  = $urandom_range(0, 9);
      wa = (r > 7) ? 5'd31 : AW'(r);
      r  = $urandom_range(0, 8);
      ra = (r == 8) ? 5'd31 : AW'(r);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0), wa,
           {$urandom, $urandom}, ($urandom_range(0, 2) == 0), ra);
    end

    // bounded final drain
    for (int i = 0; i < 20 && pend_q.size() != 0; i++) idle(1'b0, '0);
    chk("final_pending", DW'(pend_q.size()), '0);
    chk("final_scoreboard", DW'(exp_q.size()), '0);
    chk("final_count", DW'(count), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
